// File: rtl/inst_mem_fetch.sv
// Writable instruction memory with a registered read stage and an in-order
// response buffer behind a valid/ready fetch interface.
module inst_mem_fetch #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 64,
    parameter int                OUT_DEPTH = 2,
    parameter logic [DATA_W-1:0] NOP_WORD  = 32'hE3000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_instr,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_err
);
    localparam int                IDX_W = $clog2(DEPTH);
    localparam int                PTR_W = $clog2(OUT_DEPTH);
    localparam int                CNT_W = $clog2(OUT_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 4);

    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && (a < LIMIT);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUT_DEPTH - 1))
            return '0;
        return p + PTR_W'(1);
    endfunction

    // Words are stored XOR NOP_WORD so that zero-initialised storage reads back
    // as NOP_WORD without any reset or fill sequence.
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_vld_p1;
    logic [ADDR_W-1:0] r_addr_p1;
    logic              r_err_p1;
    logic [DATA_W-1:0] r_data_p1;

    logic [DATA_W-1:0] r_buf_instr [OUT_DEPTH];
    logic [ADDR_W-1:0] r_buf_addr  [OUT_DEPTH];
    logic              r_buf_err   [OUT_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_wr_ok;
    logic              w_req_ok;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_req_idx;
    logic [CNT_W:0]    w_occ;
    logic              w_head_buf;
    logic              w_pop;
    logic              w_pop_buf;
    logic              w_accept;
    logic              w_p1_to_buf;
    logic [DATA_W-1:0] w_p1_instr;
    logic [CNT_W-1:0]  w_count_nxt;

    assign w_wr_ok   = addr_legal(wr_addr);
    assign w_req_ok  = addr_legal(req_addr);
    assign w_wr_idx  = wr_addr[2 +: IDX_W];
    assign w_req_idx = req_addr[2 +: IDX_W];

    assign w_occ      = {1'b0, r_count} + (CNT_W + 1)'(r_vld_p1);
    assign w_head_buf = (r_count != '0);
    assign resp_valid = w_head_buf || r_vld_p1;
    assign w_pop      = resp_valid && resp_ready;
    assign req_ready  = !flush && ((w_occ < (CNT_W + 1)'(OUT_DEPTH)) || w_pop);
    assign w_accept   = req_valid && req_ready;

    // An in-flight word popped straight from stage p1 never enters the buffer.
    assign w_pop_buf   = w_pop && w_head_buf;
    assign w_p1_to_buf = r_vld_p1 && !(w_pop && !w_head_buf);
    assign w_p1_instr  = r_err_p1 ? NOP_WORD : r_data_p1;
    assign w_count_nxt = r_count + CNT_W'(w_p1_to_buf) - CNT_W'(w_pop_buf);

    always_ff @(posedge clk) begin
        if (wr_en && w_wr_ok)
            r_mem[w_wr_idx] <= wr_data ^ NOP_WORD;
    end

    // ---- stage p1: array read result and buffer bookkeeping ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (flush) begin
            r_vld_p1 <= 1'b0;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_vld_p1 <= w_accept;
            r_count  <= w_count_nxt;
            if (w_p1_to_buf)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop_buf)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr_p1 <= req_addr;
            r_err_p1  <= !w_req_ok;
            r_data_p1 <= r_mem[w_req_idx] ^ NOP_WORD;
        end
        if (w_p1_to_buf) begin
            r_buf_instr[r_wr_ptr] <= w_p1_instr;
            r_buf_addr[r_wr_ptr]  <= r_addr_p1;
            r_buf_err[r_wr_ptr]   <= r_err_p1;
        end
    end

    // ---- output head: oldest buffered entry, else the in-flight word ----
    always_comb begin
        resp_instr = '0;
        resp_addr  = '0;
        resp_err   = 1'b0;
        if (w_head_buf) begin
            resp_instr = r_buf_instr[r_rd_ptr];
            resp_addr  = r_buf_addr[r_rd_ptr];
            resp_err   = r_buf_err[r_rd_ptr];
        end else if (r_vld_p1) begin
            resp_instr = w_p1_instr;
            resp_addr  = r_addr_p1;
            resp_err   = r_err_p1;
        end
    end

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Bench for inst_mem_fetch: directed vector table, flush/reset sequences and
// random traffic checked against a queue-based model of the fetch memory.
module tb_inst_mem_fetch;
    localparam int          DEPTH = 64;
    localparam int          OUTD  = 2;
    localparam logic [31:0] NOP   = 32'hE3000000;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [31:0] resp_addr;
    logic        resp_err;

    inst_mem_fetch #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .OUT_DEPTH(OUTD), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flush(flush), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
        .resp_addr(resp_addr), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        fl;
        logic        rv;
        logic [31:0] ra;
        logic        rr;
        logic        x_rdy;
        logic        x_vld;
        logic [31:0] x_instr;
        logic [31:0] x_addr;
        logic        x_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } ent_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_mem [DEPTH];
    ent_t        m_q [$];
    vec_t        tbl [$];

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'(DEPTH * 4));
    endfunction

    function automatic vec_t mk(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                                input logic rv, input logic [31:0] ra, input logic rr,
                                input logic xrdy, input logic xvld, input logic [31:0] xi,
                                input logic [31:0] xa, input logic xe);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.fl = 1'b0; v.rv = rv; v.ra = ra; v.rr = rr;
        v.x_rdy = xrdy; v.x_vld = xvld; v.x_instr = xi; v.x_addr = xa; v.x_err = xe;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle, check outputs before the edge, then advance the model.
    task automatic apply(input vec_t v, input bit use_model, input string tag);
        logic        e_rdy;
        ent_t        e;
        logic        e_vld;
        @(negedge clk);
        wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; flush = v.fl;
        req_valid = v.rv; req_addr = v.ra; resp_ready = v.rr;
        #1;
        e_rdy = !v.fl && ((m_q.size() < OUTD) || (m_q.size() > 0 && v.rr));
        e_vld = (m_q.size() > 0);
        e = '{instr: 32'h0, addr: 32'h0, err: 1'b0};
        if (e_vld)
            e = m_q[0];
        if (use_model) begin
            chk({tag, ".rdy"},   32'(req_ready),  32'(e_rdy));
            chk({tag, ".vld"},   32'(resp_valid), 32'(e_vld));
            chk({tag, ".instr"}, resp_instr,      e.instr);
            chk({tag, ".addr"},  resp_addr,       e.addr);
            chk({tag, ".err"},   32'(resp_err),   32'(e.err));
        end else begin
            chk({tag, ".rdy"},   32'(req_ready),  32'(v.x_rdy));
            chk({tag, ".vld"},   32'(resp_valid), 32'(v.x_vld));
            chk({tag, ".instr"}, resp_instr,      v.x_instr);
            chk({tag, ".addr"},  resp_addr,       v.x_addr);
            chk({tag, ".err"},   32'(resp_err),   32'(v.x_err));
        end
        @(posedge clk);
        if (v.fl) begin
            m_q.delete();
        end else begin
            if (m_q.size() > 0 && v.rr)
                void'(m_q.pop_front());
            if (v.rv && e_rdy) begin
                if (legal(v.ra))
                    m_q.push_back('{instr: m_mem[v.ra[7:2]], addr: v.ra, err: 1'b0});
                else
                    m_q.push_back('{instr: NOP, addr: v.ra, err: 1'b1});
            end
        end
        if (v.we && legal(v.wa))
            m_mem[v.wa[7:2]] = v.wd;
    endtask

    function automatic vec_t mv(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                                input logic fl, input logic rv, input logic [31:0] ra,
                                input logic rr);
        vec_t v;
        v = mk(we, wa, wd, rv, ra, rr, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        v.fl = fl;
        return v;
    endfunction

    function automatic logic [31:0] rnd_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, DEPTH - 1) * 4);
        else if (r == 7) return 32'(DEPTH * 4 + $urandom_range(0, 15) * 4);
        else if (r == 8) return 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
        else             return $urandom;
    endfunction

    initial begin
        vec_t v;
        for (int i = 0; i < DEPTH; i++)
            m_mem[i] = NOP;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; flush = 1'b0;
        req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        #3;
        chk("reset.vld",   32'(resp_valid), 32'h0);
        chk("reset.instr", resp_instr,      32'h0);
        chk("reset.addr",  resp_addr,       32'h0);
        chk("reset.err",   32'(resp_err),   32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // we, wa, wd, rv, ra, rr | rdy, vld, instr, addr, err
        tbl.push_back(mk(1, 4,  32'h65000000, 0, 0,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            1, 4,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,   1, 1, 1, 32'h65000000, 4, 0));
        tbl.push_back(mk(1, 0,  32'h11110000, 0, 0,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4,  32'h22220000, 0, 0,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8,  32'h33330000, 0, 0,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 12, 32'h44440000, 0, 0,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            1, 0,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            1, 4,   1, 1, 1, 32'h11110000, 0, 0));
        tbl.push_back(mk(0, 0,  0,            1, 8,   1, 1, 1, 32'h22220000, 4, 0));
        tbl.push_back(mk(0, 0,  0,            1, 12,  1, 1, 1, 32'h33330000, 8, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,   1, 1, 1, 32'h44440000, 12, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            1, 0,   0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            1, 4,   0, 1, 1, 32'h11110000, 0, 0));
        tbl.push_back(mk(0, 0,  0,            1, 8,   0, 0, 1, 32'h11110000, 0, 0));
        tbl.push_back(mk(0, 0,  0,            1, 8,   0, 0, 1, 32'h11110000, 0, 0));
        tbl.push_back(mk(0, 0,  0,            1, 8,   1, 1, 1, 32'h11110000, 0, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,   1, 1, 1, 32'h22220000, 4, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,   1, 1, 1, 32'h33330000, 8, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            1, 256, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            1, 6,   1, 1, 1, NOP, 256, 1));
        tbl.push_back(mk(1, 256, 32'hDEADBEEF, 0, 0,  1, 1, 1, NOP, 6, 1));
        tbl.push_back(mk(0, 0,  0,            0, 0,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8,  32'hAAAA0000, 1, 8,   1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,            1, 8,   1, 1, 1, 32'h33330000, 8, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,   1, 1, 1, 32'hAAAA0000, 8, 0));
        tbl.push_back(mk(0, 0,  0,            0, 0,   1, 1, 0, 0, 0, 0));
        foreach (tbl[i])
            apply(tbl[i], 1'b0, $sformatf("tbl%0d", i));

        // Every word readable, none disturbed by the out-of-range write.
        for (int a = 0; a < DEPTH; a++)
            apply(mv(0, 0, 0, 0, 1, 32'(a * 4), 1), 1'b1, $sformatf("sweep%0d", a));
        apply(mv(0, 0, 0, 0, 0, 0, 1), 1'b1, "sweep_end");

        // Flush with one buffered and one in-flight entry; a write in that cycle lands.
        apply(mv(0, 0, 0, 0, 1, 0, 0), 1'b1, "fl_a");
        apply(mv(0, 0, 0, 0, 1, 4, 0), 1'b1, "fl_b");
        apply(mv(1, 16, 32'h5555AAAA, 1, 1, 8, 0), 1'b1, "fl_pulse");
        for (int i = 0; i < 3; i++)
            apply(mv(0, 0, 0, 0, 0, 0, 1), 1'b1, $sformatf("fl_after%0d", i));
        apply(mv(0, 0, 0, 0, 1, 16, 1), 1'b1, "fl_rd16");
        apply(mv(0, 0, 0, 0, 0, 0, 1), 1'b1, "fl_rd16_out");

        // Asynchronous reset mid-stream, memory retained.
        apply(mv(0, 0, 0, 0, 1, 0, 0), 1'b1, "rs_a");
        apply(mv(0, 0, 0, 0, 1, 4, 0), 1'b1, "rs_b");
        @(negedge clk);
        req_valid = 1'b0; wr_en = 1'b0; resp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rs_mid.vld",   32'(resp_valid), 32'h0);
        chk("rs_mid.instr", resp_instr,      32'h0);
        chk("rs_mid.addr",  resp_addr,       32'h0);
        chk("rs_mid.err",   32'(resp_err),   32'h0);
        m_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++)
            apply(mv(0, 0, 0, 0, 0, 0, 1), 1'b1, $sformatf("rs_after%0d", i));
        apply(mv(0, 0, 0, 0, 1, 4, 1), 1'b1, "rs_rd4");
        apply(mv(0, 0, 0, 0, 1, 16, 1), 1'b1, "rs_rd16");
        apply(mv(0, 0, 0, 0, 0, 0, 1), 1'b1, "rs_rd_end");

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            v = mv(($urandom_range(0, 3) == 0), rnd_addr(), $urandom,
                   ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                   rnd_addr(), ($urandom_range(0, 2) != 0));
            apply(v, 1'b1, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
